// File: rtl/imem_boot_loader.sv
// Framed byte-stream program loader: assembles little-endian words into instruction
// memory, verifies an additive checksum, then pulses the core reset and starts the core.
module imem_boot_loader #(
    parameter int unsigned IMEM_WORDS  = 256,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [31:0]       imem_write_instr,
    output logic              imem_write_en,
    output logic [ADDR_W-1:0] imem_wr_addr,
    output logic              core_reset,
    output logic              start,
    output logic              busy,
    output logic              err,
    output logic [15:0]       words_loaded
);

    localparam int unsigned WI_W = $clog2(IMEM_WORDS + 1);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0]  SYNC = 8'hA5;

    typedef enum logic [2:0] {
        IDLE, HDR_LO, HDR_HI, LOAD, CHK, BOOT, RUN, ERR
    } state_t;

    state_t          state;
    logic [7:0]      n_lo;
    logic [15:0]     n_words;
    logic [WI_W-1:0] word_index;
    logic [1:0]      byte_cnt;
    logic [23:0]     word_buf;
    logic [7:0]      checksum;
    logic [TO_W-1:0] to_cnt;

    logic        accept;
    logic        active;
    logic [15:0] hdr_n;
    logic        timed_out;

    assign accept    = s_valid & s_ready;
    assign active    = (state == HDR_LO) || (state == HDR_HI) || (state == LOAD) || (state == CHK);
    assign hdr_n     = {s_data, n_lo};
    assign timed_out = active && !accept && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            s_ready          <= 1'b1;
            imem_write_instr <= 32'd0;
            imem_write_en    <= 1'b0;
            imem_wr_addr     <= '0;
            core_reset       <= 1'b0;
            start            <= 1'b0;
            busy             <= 1'b0;
            err              <= 1'b0;
            words_loaded     <= 16'd0;
            n_lo             <= 8'd0;
            n_words          <= 16'd0;
            word_index       <= '0;
            byte_cnt         <= 2'd0;
            word_buf         <= 24'd0;
            checksum         <= 8'd0;
            to_cnt           <= '0;
        end else begin
            imem_write_en <= 1'b0;
            core_reset    <= 1'b0;

            // Inter-byte idle counter, only meaningful while a frame is in flight
            if (active && !accept) begin
                to_cnt <= to_cnt + TO_W'(1);
            end else begin
                to_cnt <= '0;
            end

            case (state)
                IDLE: begin
                    if (accept && s_data == SYNC) begin
                        state <= HDR_LO;
                        busy  <= 1'b1;
                    end
                end
                HDR_LO: begin
                    if (accept) begin
                        n_lo  <= s_data;
                        state <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (accept) begin
                        if (hdr_n == 16'd0 || hdr_n > 16'(IMEM_WORDS)) begin
                            state <= ERR;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state        <= LOAD;
                            n_words      <= hdr_n;
                            word_index   <= '0;
                            byte_cnt     <= 2'd0;
                            checksum     <= 8'd0;
                            words_loaded <= 16'd0;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        checksum <= checksum + s_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            imem_write_instr <= {s_data, word_buf};
                            imem_write_en    <= 1'b1;
                            imem_wr_addr     <= ADDR_W'({word_index, 2'b00});
                            words_loaded     <= words_loaded + 16'd1;
                            word_index       <= word_index + WI_W'(1);
                            if (16'(word_index) == n_words - 16'd1) begin
                                state <= CHK;
                            end
                        end else begin
                            word_buf[{byte_cnt, 3'b000} +: 8] <= s_data;
                        end
                    end
                end
                CHK: begin
                    if (accept) begin
                        if (s_data == checksum) begin
                            state      <= BOOT;
                            s_ready    <= 1'b0;
                            core_reset <= 1'b1;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                BOOT: begin
                    state <= RUN;
                    start <= 1'b1;
                    busy  <= 1'b0;
                end
                RUN: begin
                    state <= RUN;
                end
                ERR: begin
                    if (accept && s_data == SYNC) begin
                        state <= HDR_LO;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Stalled source inside a frame abandons it
            if (timed_out) begin
                state   <= ERR;
                err     <= 1'b1;
                busy    <= 1'b0;
                s_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected IMEM writes are queued by the stimulus
// and popped by a monitor on each write strobe; status outputs are checked after frames.
module tb_imem_boot_loader;

    localparam int unsigned TO_CYC = 40;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  s_data = 8'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] imem_write_instr;
    logic        imem_write_en;
    logic [9:0]  imem_wr_addr;
    logic        core_reset;
    logic        start;
    logic        busy;
    logic        err;
    logic [15:0] words_loaded;

    int  n_checks = 0;
    int  n_pass = 0;
    int  cr_cnt = 0;
    wr_t exp_q[$];

    imem_boot_loader #(.IMEM_WORDS(256), .ADDR_W(10), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .imem_write_instr(imem_write_instr), .imem_write_en(imem_write_en),
        .imem_wr_addr(imem_wr_addr), .core_reset(core_reset), .start(start),
        .busy(busy), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Monitor: pops the scoreboard on every write strobe, counts core reset pulses
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_write_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {22'd0, imem_wr_addr, imem_write_instr}, 64'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(imem_wr_addr), 64'(e.addr));
                    check("wr_data", 64'(imem_write_instr), 64'(e.data));
                end
            end
            if (core_reset) cr_cnt++;
        end
    end

    function automatic byte_q_t nominal(input logic [7:0] chk);
        byte_q_t q;
        q = {8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
             8'h13, 8'h81, 8'h10, 8'h00, chk};
        return q;
    endfunction

    task automatic expect_nominal();
        exp_q.push_back('{addr: 10'd0, data: 32'h0050_0093});
        exp_q.push_back('{addr: 10'd4, data: 32'h0010_8113});
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        n = 0;
        @(negedge clk);
        s_data  = b;
        s_valid = 1'b1;
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            check("handshake_timeout", 64'(s_ready), 64'd1);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                s_valid = 1'b0;
                s_data  = 8'($urandom);
            end
        end
    endtask

    task automatic send_frame(input byte_q_t fr, input bit gaps);
        foreach (fr[i]) send_byte(fr[i], gaps);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset   = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        check({tag, "_ctrl"}, 64'({s_ready, imem_write_en, core_reset, start, busy, err}),
              64'(6'b100000));
        check({tag, "_data"}, {imem_write_instr, 6'd0, imem_wr_addr, words_loaded}, 64'd0);
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_run(input string tag, input int cr0);
        check({tag, "_start"}, 64'(start), 64'd1);
        check({tag, "_ready_err_busy"}, 64'({s_ready, err, busy}), 64'd0);
        check({tag, "_words"}, 64'(words_loaded), 64'd2);
        check({tag, "_core_reset_pulses"}, 64'(cr_cnt - cr0), 64'd1);
        check({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cr0;
        int n;
        byte_q_t q;

        do_reset("reset0");

        // 1: nominal frame
        cr0 = cr_cnt;
        expect_nominal();
        send_frame(nominal(8'h87), 1'b0);
        check_run("nominal", cr0);

        // 2: bad checksum
        do_reset("reset_t2");
        cr0 = cr_cnt;
        expect_nominal();
        send_frame(nominal(8'h88), 1'b0);
        check("badchk_err", 64'({err, start, busy, s_ready}), 64'(4'b1001));
        check("badchk_no_core_reset", 64'(cr_cnt - cr0), 64'd0);
        check("badchk_queue", 64'(exp_q.size()), 64'd0);

        // 3: oversize and empty headers, starting from ERR
        q = {8'hA5, 8'h01, 8'h01};
        send_frame(q, 1'b0);
        check("oversize_err", 64'({err, busy, start}), 64'(3'b100));
        q = {8'hA5, 8'h00, 8'h00};
        send_frame(q, 1'b0);
        check("empty_err", 64'({err, busy, start}), 64'(3'b100));

        // 4: recovery from ERR, then garbage before a frame
        cr0 = cr_cnt;
        expect_nominal();
        send_frame(nominal(8'h87), 1'b0);
        check_run("from_err", cr0);

        do_reset("reset_t4");
        cr0 = cr_cnt;
        q = {8'h00, 8'hFF, 8'h5A};
        send_frame(q, 1'b0);
        check("garbage_idle", 64'({busy, err, s_ready}), 64'(3'b001));
        expect_nominal();
        send_frame(nominal(8'h87), 1'b0);
        check_run("garbage", cr0);

        // 5: timeout mid-word
        do_reset("reset_t5");
        q = {8'hA5, 8'h01, 8'h00, 8'h93, 8'h00};
        send_frame(q, 1'b0);
        check("timeout_busy_before", 64'({busy, err}), 64'(2'b10));
        n = 0;
        while (!err && n < int'(TO_CYC) + 20) begin
            @(negedge clk);
            n++;
        end
        check("timeout_err", 64'({err, busy, s_ready}), 64'(3'b101));
        check("timeout_no_write", 64'(exp_q.size()), 64'd0);

        // 6: reset after the 6th payload byte, then reload with random gaps
        do_reset("reset_t6a");
        exp_q.push_back('{addr: 10'd0, data: 32'h0050_0093});
        q = {8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h81};
        foreach (q[i]) send_byte(q[i], 1'b0);
        check("midload_busy", 64'({busy, words_loaded}), {47'd0, 1'b1, 16'd1});
        check("midload_queue", 64'(exp_q.size()), 64'd0);
        do_reset("reset_midload");
        cr0 = cr_cnt;
        expect_nominal();
        send_frame(nominal(8'h87), 1'b1);
        check_run("gapped", cr0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
